// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port on-chip RAM.
// Registered round-robin grant per bus cycle, with a strobe watchdog.
module wb_ram_arbiter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,

   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,

   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam int TO_LAST_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [1:0]       arb_pick;
   logic             last_grant;
   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;
   logic             gnt0;
   logic             gnt1;
   logic             state_chg;
   logic             wd_hit;

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   // last_grant names the previous winner; a tie goes to the other master
   always_comb begin
      arb_pick = IDLE;
      case ({m0_cyc_i, m1_cyc_i})
         2'b10:   arb_pick = GNT0;
         2'b01:   arb_pick = GNT1;
         2'b11:   arb_pick = last_grant ? GNT0 : GNT1;
         default: arb_pick = IDLE;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = arb_pick;
         GNT0:    if (!m0_cyc_i) state_nxt = arb_pick;
         GNT1:    if (!m1_cyc_i) state_nxt = arb_pick;
         default: state_nxt = IDLE;
      endcase
   end

   assign state_chg = (state_nxt != state);

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = 4'h0;
      s_adr_o = 32'h0;
      s_dat_o = 32'h0;
      if (gnt0) begin
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i;
         s_we_o  = m0_we_i;
         s_sel_o = m0_sel_i;
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
      end else if (gnt1) begin
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i;
         s_we_o  = m1_we_i;
         s_sel_o = m1_sel_i;
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
      end
   end

   // An ack in the expiring cycle wins; a handover never carries an error
   assign wd_hit = WD_EN && s_stb_o && !s_ack_i &&
                   (wd_cnt == TO_LAST) && !state_chg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_chg && state_nxt == GNT0)
            last_grant <= 1'b0;
         else if (state_chg && state_nxt == GNT1)
            last_grant <= 1'b1;
         err_q <= wd_hit;
         if (state_chg || s_ack_i || !s_stb_o || wd_hit)
            wd_cnt <= '0;
         else if (wd_cnt != CNT_MAX)
            wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   assign m0_ack_o = s_ack_i & gnt0 & ~err_q;
   assign m1_ack_o = s_ack_i & gnt1 & ~err_q;
   assign m0_err_o = err_q & gnt0;
   assign m1_err_o = err_q & gnt1;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios plus a randomized run
// against a cycle-level model of grant ownership and strobe timeouts.
module tb_wb_ram_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        m0_cyc, m0_stb, m0_we;
   logic [3:0]  m0_sel;
   logic [31:0] m0_adr, m0_wdat;
   logic [31:0] m0_rdat;
   logic        m0_ack, m0_err;

   logic        m1_cyc, m1_stb, m1_we;
   logic [3:0]  m1_sel;
   logic [31:0] m1_adr, m1_wdat;
   logic [31:0] m1_rdat;
   logic        m1_ack, m1_err;

   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat;
   logic [31:0] s_rdat;
   logic        s_ack;

   logic        mute;
   logic [31:0] mem [0:63];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   wb_ram_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
      .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
      .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
      .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
      .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
      .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
      .s_dat_i(s_rdat), .s_ack_i(s_ack)
   );

   // RAM slave: one-cycle registered ack, muteable to provoke timeouts
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ack  <= 1'b0;
         s_rdat <= 32'h0;
         for (int i = 0; i < 64; i++)
            mem[i] <= (i == 4) ? 32'hDEADBEEF : (32'hAAAAAA00 | i);
      end else begin
         s_ack <= s_stb & ~s_ack & ~mute;
         if (s_stb & ~s_ack & ~mute) begin
            s_rdat <= mem[s_adr[7:2]];
            if (s_we)
               for (int b = 0; b < 4; b++)
                  if (s_sel[b])
                     mem[s_adr[7:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
         end
      end
   end

   task automatic clear_masters();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0;
      m0_adr = 0; m0_wdat = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0;
      m1_adr = 0; m1_wdat = 0;
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_masters();
      mute = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      clear_masters();
      mute = 0;
      rst = 1;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0)
         $display("FAIL reset_slave cyc=%0b stb=%0b want 0 0", s_cyc, s_stb);
      else passed++;
      total++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0)
         $display("FAIL reset_resp got %b want 0000",
                  {m0_ack, m0_err, m1_ack, m1_err});
      else passed++;
      total++;
      if (s_adr !== 32'h0)
         $display("FAIL reset_adr got %h want 0", s_adr);
      else passed++;
      do_reset();
   endtask

   task automatic test_m0_read();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; m0_sel = 4'hF;
      @(negedge clk);
      total++;
      if (s_stb !== 1'b0)
         $display("FAIL read_pregrant stb=%0b want 0", s_stb);
      else passed++;
      cyc1();
      total++;
      if (s_stb !== 1'b1 || s_adr !== 32'h10)
         $display("FAIL read_grant stb=%0b adr=%h want 1 10", s_stb, s_adr);
      else passed++;
      total++;
      if (m0_ack !== 1'b0)
         $display("FAIL read_early_ack got %0b want 0", m0_ack);
      else passed++;
      cyc1();
      total++;
      if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEADBEEF)
         $display("FAIL read_ack ack=%0b dat=%h want 1 deadbeef",
                  m0_ack, m0_rdat);
      else passed++;
      total++;
      if (m1_ack !== 1'b0)
         $display("FAIL read_m1_ack got %0b want 0", m1_ack);
      else passed++;
      clear_masters();
      cyc1();
   endtask

   task automatic test_round_robin();
      do_reset();
      m0_cyc = 1; m0_adr = 32'h100;
      m1_cyc = 1; m1_adr = 32'h200;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h100)
         $display("FAIL rr_first cyc=%0b adr=%h want 1 100", s_cyc, s_adr);
      else passed++;
      cyc1();
      total++;
      if (s_adr !== 32'h100)
         $display("FAIL rr_hold adr=%h want 100", s_adr);
      else passed++;
      m0_cyc = 0;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h200)
         $display("FAIL rr_handover cyc=%0b adr=%h want 1 200", s_cyc, s_adr);
      else passed++;
      m1_cyc = 0;
      cyc1();
      total++;
      if (s_cyc !== 1'b0)
         $display("FAIL rr_idle cyc=%0b want 0", s_cyc);
      else passed++;
      m0_cyc = 1;
      cyc1();
      m0_cyc = 0;
      cyc1();
      m0_cyc = 1; m1_cyc = 1;
      cyc1();
      total++;
      if (s_adr !== 32'h200)
         $display("FAIL rr_second_m1 adr=%h want 200", s_adr);
      else passed++;
      m1_cyc = 0;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h100)
         $display("FAIL rr_second_m0 cyc=%0b adr=%h want 1 100", s_cyc, s_adr);
      else passed++;
      clear_masters();
      cyc1();
   endtask

   task automatic test_back_to_back();
      bit got;
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011;
      m1_adr = 32'h20; m1_wdat = 32'h1;
      cyc1();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40; m0_sel = 4'hF;
      for (int b = 0; b < 3; b++) begin
         m1_adr = 32'h20 + 32'(4 * b);
         m1_wdat = 32'(b + 1);
         got = 0;
         for (int k = 0; k < 8 && !got; k++) begin
            cyc1();
            total++;
            if (s_adr !== m1_adr || m0_ack !== 1'b0)
               $display("FAIL b2b_owner adr=%h m0_ack=%0b want %h 0",
                        s_adr, m0_ack, m1_adr);
            else passed++;
            if (m1_ack === 1'b1) got = 1;
         end
         total++;
         if (!got || s_wdat !== 32'(b + 1) || s_sel !== 4'b0011)
            $display("FAIL b2b_beat%0d ack=%0b dat=%h sel=%b want 1 %h 0011",
                     b, got, s_wdat, s_sel, b + 1);
         else passed++;
      end
      m1_cyc = 0; m1_stb = 0; m1_we = 0;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h40)
         $display("FAIL b2b_m0_grant cyc=%0b adr=%h want 1 40", s_cyc, s_adr);
      else passed++;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         cyc1();
         if (m0_ack === 1'b1) got = 1;
      end
      total++;
      if (!got)
         $display("FAIL b2b_m0_ack got 0 want 1");
      else passed++;
      clear_masters();
      cyc1();
      for (int b = 0; b < 3; b++) begin
         total++;
         if (mem[8 + b] !== (32'hAAAA0000 | 32'(b + 1)))
            $display("FAIL b2b_mem%0d got %h want %h",
                     b, mem[8 + b], 32'hAAAA0000 | 32'(b + 1));
         else passed++;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mute = 1;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || m0_err !== 1'b0)
         $display("FAIL to_grant cyc=%0b err=%0b want 1 0", s_cyc, m0_err);
      else passed++;
      for (int k = 1; k < TO; k++) begin
         cyc1();
         total++;
         if (m0_err !== 1'b0)
            $display("FAIL to_early%0d err=%0b want 0", k, m0_err);
         else passed++;
      end
      cyc1();
      total++;
      if (m0_err !== 1'b1 || m0_ack !== 1'b0 || m1_err !== 1'b0)
         $display("FAIL to_fire err=%0b ack=%0b m1err=%0b want 1 0 0",
                  m0_err, m0_ack, m1_err);
      else passed++;
      cyc1();
      total++;
      if (m0_err !== 1'b0 || s_cyc !== 1'b1)
         $display("FAIL to_pulse err=%0b cyc=%0b want 0 1", m0_err, s_cyc);
      else passed++;
      clear_masters();
      cyc1();
      total++;
      if (s_cyc !== 1'b0 || m0_err !== 1'b0)
         $display("FAIL to_release cyc=%0b err=%0b want 0 0", s_cyc, m0_err);
      else passed++;
      mute = 0;
   endtask

   task automatic test_ack_vs_timeout();
      do_reset();
      mute = 1;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h14;
      cyc1();
      cyc1();
      cyc1();
      mute = 0;
      cyc1();
      total++;
      if (m0_ack !== 1'b1 || m0_err !== 1'b0)
         $display("FAIL race_ack ack=%0b err=%0b want 1 0", m0_ack, m0_err);
      else passed++;
      mute = 1;
      cyc1();
      total++;
      if (m0_err !== 1'b0 || m0_ack !== 1'b0)
         $display("FAIL race_noerr err=%0b ack=%0b want 0 0", m0_err, m0_ack);
      else passed++;
      clear_masters();
      cyc1();
      mute = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      mute = 1;
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
      m1_adr = 32'h30; m1_wdat = 32'h55;
      cyc1();
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_we !== 1'b1)
         $display("FAIL ar_pre cyc=%0b we=%0b want 1 1", s_cyc, s_we);
      else passed++;
      #2 rst = 1;
      #1;
      total++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_we !== 1'b0)
         $display("FAIL ar_drop cyc=%0b stb=%0b we=%0b want 0 0 0",
                  s_cyc, s_stb, s_we);
      else passed++;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
      @(negedge clk);
      rst = 0;
      cyc1();
      total++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h40)
         $display("FAIL ar_regrant cyc=%0b adr=%h want 1 40", s_cyc, s_adr);
      else passed++;
      clear_masters();
      cyc1();
      mute = 0;
   endtask

   task automatic test_random();
      int owner;
      int prefer;
      int cnt;
      int nxt;
      bit err;
      bit stb_m;
      logic        e_cyc, e_stb;
      logic [31:0] e_adr, e_dat;
      int errs_seen;
      do_reset();
      owner = 0; prefer = 0; cnt = 0; err = 0; errs_seen = 0;
      for (int n = 0; n < 400; n++) begin
         m0_cyc = m0_cyc ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
         m1_cyc = m1_cyc ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
         m0_stb = m0_cyc & ($urandom % 5 != 0);
         m1_stb = m1_cyc & ($urandom % 5 != 0);
         m0_we = 1'($urandom); m1_we = 1'($urandom);
         m0_sel = 4'($urandom); m1_sel = 4'($urandom);
         m0_adr = $urandom; m1_adr = $urandom;
         m0_wdat = $urandom; m1_wdat = $urandom;
         mute = ($urandom % 3 != 0);
         @(negedge clk);
         e_cyc = (owner == 1) ? m0_cyc : (owner == 2) ? m1_cyc : 1'b0;
         e_stb = (owner == 1) ? m0_stb : (owner == 2) ? m1_stb : 1'b0;
         e_adr = (owner == 1) ? m0_adr : (owner == 2) ? m1_adr : 32'h0;
         e_dat = (owner == 1) ? m0_wdat : (owner == 2) ? m1_wdat : 32'h0;
         total++;
         if (s_cyc !== e_cyc || s_stb !== e_stb)
            $display("FAIL rnd_ctl n=%0d cyc=%0b stb=%0b want %0b %0b",
                     n, s_cyc, s_stb, e_cyc, e_stb);
         else passed++;
         total++;
         if (s_adr !== e_adr || s_wdat !== e_dat)
            $display("FAIL rnd_bus n=%0d adr=%h dat=%h want %h %h",
                     n, s_adr, s_wdat, e_adr, e_dat);
         else passed++;
         total++;
         if (m0_ack !== (s_ack & (owner == 1) & ~err) ||
             m1_ack !== (s_ack & (owner == 2) & ~err))
            $display("FAIL rnd_ack n=%0d got %b%b owner=%0d err=%0b",
                     n, m0_ack, m1_ack, owner, err);
         else passed++;
         total++;
         if (m0_err !== (err & (owner == 1)) ||
             m1_err !== (err & (owner == 2)))
            $display("FAIL rnd_err n=%0d got %b%b want owner=%0d err=%0b",
                     n, m0_err, m1_err, owner, err);
         else passed++;
         total++;
         if (m0_rdat !== s_rdat || m1_rdat !== s_rdat)
            $display("FAIL rnd_rdat n=%0d got %h %h want %h",
                     n, m0_rdat, m1_rdat, s_rdat);
         else passed++;
         if (err) errs_seen++;
         if (owner == 0 || (owner == 1 && !m0_cyc) || (owner == 2 && !m1_cyc)) begin
            if (m0_cyc && m1_cyc) nxt = prefer + 1;
            else if (m0_cyc) nxt = 1;
            else if (m1_cyc) nxt = 2;
            else nxt = 0;
         end else nxt = owner;
         stb_m = e_stb;
         if (nxt != owner || s_ack || !stb_m) begin
            cnt = 0; err = 0;
         end else if (cnt == TO - 1) begin
            cnt = 0; err = 1;
         end else begin
            cnt++; err = 0;
         end
         if (nxt != owner && nxt != 0) prefer = (nxt == 1) ? 1 : 0;
         owner = nxt;
         cyc1();
      end
      clear_masters();
      mute = 0;
      cyc1();
      cyc1();
      if (errs_seen == 0)
         $display("note: random run produced no timeout");
   endtask

   initial begin
      clear_masters();
      mute = 0;
      test_reset();
      test_m0_read();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_ack_vs_timeout();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout time=%0t", $time);
      $fatal(1, "bench did not finish");
   end

endmodule
